// File: rtl/common_pkg.sv
// rtl/common_pkg.sv - shared NoC flit and arbiter state types
package common_pkg;

   localparam int NOC_DATA_W = 32;
   localparam int NOC_DEST_W = 4;

   typedef struct packed {
      logic                  is_reply;
      logic                  last;
      logic [NOC_DEST_W-1:0] dest;
      logic [NOC_DATA_W-1:0] data;
   } noc_flit_t;

   typedef enum logic [1:0] {
      IDLE,
      REP_PKT,
      REQ_PKT
   } arb_state_e;

endpackage

// File: rtl/noc_credit_counter.sv
// rtl/noc_credit_counter.sv - downstream buffer credit counter
// A return while already full is dropped; the count never leaves 0..CREDITS.
module noc_credit_counter #(
   parameter int CREDITS = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           consume,
   input  logic                           credit_return,
   output logic [$clog2(CREDITS+1)-1:0]   count,
   output logic                           nonzero
);

   localparam int CNT_W = $clog2(CREDITS + 1);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(CREDITS);
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= FULL;
      end else if (consume && !credit_return) begin
         count <= count - ONE;
      end else if (credit_return && !consume && count != FULL) begin
         count <= count + ONE;
      end
   end

   assign nonzero = (count != '0);

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(credit_return && !consume && count == FULL));
         assert (count <= FULL);
      end
   end

endmodule

// File: rtl/noc_tx_arbiter.sv
// rtl/noc_tx_arbiter.sv - packet-atomic reply/request arbiter onto a credited NoC link
// Replies take priority; a starvation counter forces a request through after STARVE_LIMIT replies.
module noc_tx_arbiter
   import common_pkg::*;
#(
   parameter int DATA_W       = 32,
   parameter int DEST_W       = 4,
   parameter int CREDITS      = 4,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [DATA_W-1:0]              rep_tdata,
   input  logic [DEST_W-1:0]              rep_tdest,
   input  logic                           rep_tlast,
   input  logic                           rep_tvalid,
   output logic                           rep_tready,
   input  logic [DATA_W-1:0]              req_tdata,
   input  logic [DEST_W-1:0]              req_tdest,
   input  logic                           req_tlast,
   input  logic                           req_tvalid,
   output logic                           req_tready,
   output logic [DATA_W+DEST_W+1:0]       noc_tx_flit,
   output logic                           noc_tx_valid,
   input  logic                           noc_tx_credit,
   output logic [$clog2(CREDITS+1)-1:0]   credit_count
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   arb_state_e      state, next_state;
   logic [SW-1:0]   starve_cnt;
   logic            can_send;
   logic            rep_acc, req_acc;
   logic            first_beat;

   assign rep_acc    = rep_tvalid && rep_tready;
   assign req_acc    = req_tvalid && req_tready;
   assign first_beat = (state == IDLE);

   always_comb begin
      next_state = state;
      rep_tready = 1'b0;
      req_tready = 1'b0;
      case (state)
         IDLE: begin
            if (req_tvalid && (!rep_tvalid || starve_cnt == STARVE_MAX)) begin
               req_tready = can_send;
            end else if (rep_tvalid) begin
               rep_tready = can_send;
            end
         end
         REP_PKT: rep_tready = can_send;
         REQ_PKT: req_tready = can_send;
         default: next_state = IDLE;
      endcase
      if (rst) begin
         rep_tready = 1'b0;
         req_tready = 1'b0;
      end
      // Single-beat packets never leave IDLE, so back-to-back packets need no bubble.
      if (rep_tvalid && rep_tready) begin
         next_state = rep_tlast ? IDLE : REP_PKT;
      end else if (req_tvalid && req_tready) begin
         next_state = req_tlast ? IDLE : REQ_PKT;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         starve_cnt   <= '0;
         noc_tx_valid <= 1'b0;
         noc_tx_flit  <= '0;
      end else begin
         state        <= next_state;
         noc_tx_valid <= rep_acc || req_acc;
         if (first_beat && req_acc) begin
            starve_cnt <= '0;
         end else if (first_beat && rep_acc && req_tvalid && starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + SW'(1);
         end
         if (rep_acc) begin
            noc_tx_flit <= {1'b1, rep_tlast, rep_tdest, rep_tdata};
         end else if (req_acc) begin
            noc_tx_flit <= {1'b0, req_tlast, req_tdest, req_tdata};
         end
      end
   end

   noc_credit_counter #(
      .CREDITS (CREDITS)
   ) u_credit (
      .clk           (clk),
      .rst           (rst),
      .consume       (rep_acc || req_acc),
      .credit_return (noc_tx_credit),
      .count         (credit_count),
      .nonzero       (can_send)
   );

   // Inside a packet the flit register still holds the owner's previous beat.
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(rep_tready && req_tready));
         if (state == REP_PKT && rep_tvalid) assert (rep_tdest == noc_tx_flit[DATA_W +: DEST_W]);
         if (state == REQ_PKT && req_tvalid) assert (req_tdest == noc_tx_flit[DATA_W +: DEST_W]);
      end
   end

endmodule

// File: tb/tb_noc_tx_arbiter.sv
// tb/tb_noc_tx_arbiter.sv - self-checking bench for noc_tx_arbiter
module tb_noc_tx_arbiter;

   localparam int DATA_W       = 32;
   localparam int DEST_W       = 4;
   localparam int CREDITS      = 4;
   localparam int STARVE_LIMIT = 2;
   localparam int FLIT_W       = DATA_W + DEST_W + 2;
   localparam int CW           = $clog2(CREDITS + 1);

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [DATA_W-1:0] rep_tdata = '0, req_tdata = '0;
   logic [DEST_W-1:0] rep_tdest = '0, req_tdest = '0;
   logic              rep_tlast = 1'b0, req_tlast = 1'b0;
   logic              rep_tvalid = 1'b0, req_tvalid = 1'b0;
   logic              rep_tready, req_tready;
   logic [FLIT_W-1:0] noc_tx_flit;
   logic              noc_tx_valid;
   logic              noc_tx_credit = 1'b0;
   logic [CW-1:0]     credit_count;

   int checks = 0;
   int failures = 0;

   noc_tx_arbiter #(
      .DATA_W       (DATA_W),
      .DEST_W       (DEST_W),
      .CREDITS      (CREDITS),
      .STARVE_LIMIT (STARVE_LIMIT)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .rep_tdata     (rep_tdata),
      .rep_tdest     (rep_tdest),
      .rep_tlast     (rep_tlast),
      .rep_tvalid    (rep_tvalid),
      .rep_tready    (rep_tready),
      .req_tdata     (req_tdata),
      .req_tdest     (req_tdest),
      .req_tlast     (req_tlast),
      .req_tvalid    (req_tvalid),
      .req_tready    (req_tready),
      .noc_tx_flit   (noc_tx_flit),
      .noc_tx_valid  (noc_tx_valid),
      .noc_tx_credit (noc_tx_credit),
      .credit_count  (credit_count)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      rep_tvalid    = 1'b0;
      req_tvalid    = 1'b0;
      noc_tx_credit = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      rep_tvalid = 1'b1; req_tvalid = 1'b1; rep_tlast = 1'b1; req_tlast = 1'b1;
      repeat (3) begin
         tick;
         checks++; if (rep_tready !== 1'b0) begin failures++; $display("FAIL reset_rep_tready got=%b exp=0", rep_tready); end
         checks++; if (req_tready !== 1'b0) begin failures++; $display("FAIL reset_req_tready got=%b exp=0", req_tready); end
         checks++; if (credit_count !== CW'(CREDITS)) begin failures++; $display("FAIL reset_credit got=%0d exp=%0d", credit_count, CREDITS); end
         checks++; if (noc_tx_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", noc_tx_valid); end
         checks++; if (noc_tx_flit !== '0) begin failures++; $display("FAIL reset_flit got=%h exp=0", noc_tx_flit); end
      end
      rst = 1'b0;
      idle_inputs;
      repeat (3) begin
         tick;
         checks++; if (credit_count !== CW'(CREDITS)) begin failures++; $display("FAIL idle_credit got=%0d exp=%0d", credit_count, CREDITS); end
         checks++; if (noc_tx_valid !== 1'b0) begin failures++; $display("FAIL idle_valid got=%b exp=0", noc_tx_valid); end
         checks++; if (noc_tx_flit !== '0) begin failures++; $display("FAIL idle_flit got=%h exp=0", noc_tx_flit); end
      end
   endtask

   task automatic test_req_packet;
      logic [FLIT_W-1:0] exp;
      for (int k = 0; k < 3; k++) begin
         req_tvalid = 1'b1;
         req_tdata  = 32'h1000 + k;
         req_tdest  = 4'h5;
         req_tlast  = (k == 2);
         #1;
         checks++; if (req_tready !== 1'b1) begin failures++; $display("FAIL reqpkt_ready beat=%0d got=%b exp=1", k, req_tready); end
         checks++; if (rep_tready !== 1'b0) begin failures++; $display("FAIL reqpkt_rep_ready beat=%0d got=%b exp=0", k, rep_tready); end
         tick;
         exp = {1'b0, (k == 2), 4'h5, 32'h1000 + k};
         checks++; if (noc_tx_valid !== 1'b1 || noc_tx_flit !== exp) begin
            failures++; $display("FAIL reqpkt_flit beat=%0d got=%b/%h exp=1/%h", k, noc_tx_valid, noc_tx_flit, exp);
         end
      end
      req_tvalid = 1'b0;
      checks++; if (credit_count !== CW'(1)) begin failures++; $display("FAIL reqpkt_credit got=%0d exp=1", credit_count); end
      tick;
      checks++; if (noc_tx_valid !== 1'b0) begin failures++; $display("FAIL reqpkt_valid_drop got=%b exp=0", noc_tx_valid); end
      noc_tx_credit = 1'b1;
      repeat (3) tick;
      noc_tx_credit = 1'b0;
      checks++; if (credit_count !== CW'(CREDITS)) begin failures++; $display("FAIL reqpkt_refill got=%0d exp=%0d", credit_count, CREDITS); end
   endtask

   task automatic test_credit_stall;
      logic [FLIT_W-1:0] exp;
      for (int k = 0; k < CREDITS; k++) begin
         rep_tvalid = 1'b1; rep_tdata = 32'h2000 + k; rep_tdest = 4'h3; rep_tlast = 1'b0;
         #1;
         checks++; if (rep_tready !== 1'b1) begin failures++; $display("FAIL stall_ready beat=%0d got=%b exp=1", k, rep_tready); end
         tick;
      end
      rep_tdata = 32'h2000 + CREDITS; rep_tlast = 1'b1;
      #1;
      checks++; if (rep_tready !== 1'b0 || credit_count !== '0) begin
         failures++; $display("FAIL stall_blocked got=%b/%0d exp=0/0", rep_tready, credit_count);
      end
      tick;
      checks++; if (noc_tx_valid !== 1'b0) begin failures++; $display("FAIL stall_no_flit got=%b exp=0", noc_tx_valid); end
      noc_tx_credit = 1'b1;
      #1;
      checks++; if (rep_tready !== 1'b0) begin failures++; $display("FAIL stall_credit_cycle_ready got=%b exp=0", rep_tready); end
      tick;
      noc_tx_credit = 1'b0;
      #1;
      checks++; if (credit_count !== CW'(1) || rep_tready !== 1'b1) begin
         failures++; $display("FAIL stall_resume got=%0d/%b exp=1/1", credit_count, rep_tready);
      end
      tick;
      rep_tvalid = 1'b0;
      exp = {1'b1, 1'b1, 4'h3, 32'h2000 + CREDITS};
      checks++; if (noc_tx_valid !== 1'b1 || noc_tx_flit !== exp) begin
         failures++; $display("FAIL stall_flit got=%b/%h exp=1/%h", noc_tx_valid, noc_tx_flit, exp);
      end
      checks++; if (credit_count !== '0) begin failures++; $display("FAIL stall_credit_after got=%0d exp=0", credit_count); end
      noc_tx_credit = 1'b1;
      repeat (CREDITS) tick;
      noc_tx_credit = 1'b0;
   endtask

   task automatic test_starvation_order;
      logic exp_rep;
      rep_tvalid = 1'b1; rep_tlast = 1'b1; rep_tdest = 4'h1; rep_tdata = 32'hAAAA;
      req_tvalid = 1'b1; req_tlast = 1'b1; req_tdest = 4'h2; req_tdata = 32'hBBBB;
      noc_tx_credit = 1'b1;
      for (int i = 0; i < 2 * (STARVE_LIMIT + 1); i++) begin
         tick;
         exp_rep = ((i % (STARVE_LIMIT + 1)) != STARVE_LIMIT);
         checks++; if (noc_tx_valid !== 1'b1 || noc_tx_flit[FLIT_W-1] !== exp_rep) begin
            failures++; $display("FAIL starve_order slot=%0d got=%b/%b exp=1/%b", i, noc_tx_valid, noc_tx_flit[FLIT_W-1], exp_rep);
         end
      end
      idle_inputs;
      tick;
      checks++; if (credit_count !== CW'(CREDITS)) begin failures++; $display("FAIL starve_credit got=%0d exp=%0d", credit_count, CREDITS); end
   endtask

   task automatic test_mid_packet_hold;
      logic [FLIT_W-1:0] exp;
      noc_tx_credit = 1'b1;
      for (int k = 0; k < 4; k++) begin
         req_tvalid = 1'b1; req_tdata = 32'h3000 + k; req_tdest = 4'h7; req_tlast = (k == 3);
         if (k == 1) begin
            rep_tvalid = 1'b1; rep_tdata = 32'h4444; rep_tdest = 4'h9; rep_tlast = 1'b1;
         end
         #1;
         checks++; if (req_tready !== 1'b1) begin failures++; $display("FAIL hold_req_ready beat=%0d got=%b exp=1", k, req_tready); end
         if (k >= 1) begin
            checks++; if (rep_tready !== 1'b0) begin failures++; $display("FAIL hold_rep_ready beat=%0d got=%b exp=0", k, rep_tready); end
         end
         tick;
      end
      req_tvalid = 1'b0;
      #1;
      checks++; if (rep_tready !== 1'b1) begin failures++; $display("FAIL hold_rep_after got=%b exp=1", rep_tready); end
      tick;
      exp = {1'b1, 1'b1, 4'h9, 32'h4444};
      checks++; if (noc_tx_valid !== 1'b1 || noc_tx_flit !== exp) begin
         failures++; $display("FAIL hold_rep_flit got=%b/%h exp=1/%h", noc_tx_valid, noc_tx_flit, exp);
      end
      idle_inputs;
      checks++; if (credit_count !== CW'(CREDITS)) begin failures++; $display("FAIL hold_credit got=%0d exp=%0d", credit_count, CREDITS); end
   endtask

   task automatic test_credit_simultaneous;
      req_tvalid = 1'b1; req_tlast = 1'b1; req_tdest = 4'h4; req_tdata = 32'h5555;
      tick;
      req_tvalid = 1'b0;
      checks++; if (credit_count !== CW'(CREDITS - 1)) begin failures++; $display("FAIL simul_pre got=%0d exp=%0d", credit_count, CREDITS - 1); end
      req_tvalid = 1'b1; noc_tx_credit = 1'b1;
      #1;
      checks++; if (req_tready !== 1'b1) begin failures++; $display("FAIL simul_ready got=%b exp=1", req_tready); end
      tick;
      req_tvalid = 1'b0; noc_tx_credit = 1'b0;
      checks++; if (credit_count !== CW'(CREDITS - 1)) begin failures++; $display("FAIL simul_same got=%0d exp=%0d", credit_count, CREDITS - 1); end
      noc_tx_credit = 1'b1;
      tick;
      noc_tx_credit = 1'b0;
      checks++; if (credit_count !== CW'(CREDITS)) begin failures++; $display("FAIL simul_return got=%0d exp=%0d", credit_count, CREDITS); end
   endtask

   // Cycle-level model: owner, starvation count and credits tracked as plain integers.
   task automatic test_random;
      int m_owner, m_starve, m_cred, win, r_left, q_left;
      logic m_valid, exp_rr, exp_qr, acc_r, acc_q;
      logic [FLIT_W-1:0] m_flit;
      idle_inputs;
      rst = 1'b1;
      tick; tick;
      rst = 1'b0;
      m_owner = 0; m_starve = 0; m_cred = CREDITS; m_valid = 1'b0; m_flit = '0;
      r_left = 0; q_left = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         checks++; if (noc_tx_valid !== m_valid) begin failures++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", cyc, noc_tx_valid, m_valid); end
         checks++; if (noc_tx_flit !== m_flit) begin failures++; $display("FAIL rand_flit cyc=%0d got=%h exp=%h", cyc, noc_tx_flit, m_flit); end
         checks++; if (credit_count !== CW'(m_cred)) begin failures++; $display("FAIL rand_credit cyc=%0d got=%0d exp=%0d", cyc, credit_count, m_cred); end
         if (!rep_tvalid && $urandom_range(0, 3) != 0) begin
            if (r_left == 0) begin r_left = $urandom_range(1, 4); rep_tdest = DEST_W'($urandom); end
            rep_tdata = $urandom; rep_tlast = (r_left == 1); rep_tvalid = 1'b1;
         end
         if (!req_tvalid && $urandom_range(0, 3) != 0) begin
            if (q_left == 0) begin q_left = $urandom_range(1, 4); req_tdest = DEST_W'($urandom); end
            req_tdata = $urandom; req_tlast = (q_left == 1); req_tvalid = 1'b1;
         end
         noc_tx_credit = (m_cred < CREDITS) && ($urandom_range(0, 2) != 0);
         #1;
         if (m_owner != 0) win = m_owner;
         else if (req_tvalid && (!rep_tvalid || m_starve == STARVE_LIMIT)) win = 2;
         else if (rep_tvalid) win = 1;
         else win = 0;
         exp_rr = (win == 1) && (m_cred > 0);
         exp_qr = (win == 2) && (m_cred > 0);
         checks++; if (rep_tready !== exp_rr || req_tready !== exp_qr) begin
            failures++; $display("FAIL rand_ready cyc=%0d got=%b%b exp=%b%b", cyc, rep_tready, req_tready, exp_rr, exp_qr);
         end
         acc_r = rep_tvalid && exp_rr;
         acc_q = req_tvalid && exp_qr;
         m_valid = acc_r || acc_q;
         if (acc_r) begin
            if (m_owner == 0 && req_tvalid && m_starve < STARVE_LIMIT) m_starve++;
            m_flit  = {1'b1, rep_tlast, rep_tdest, rep_tdata};
            m_owner = rep_tlast ? 0 : 1;
         end else if (acc_q) begin
            if (m_owner == 0) m_starve = 0;
            m_flit  = {1'b0, req_tlast, req_tdest, req_tdata};
            m_owner = req_tlast ? 0 : 2;
         end
         m_cred = m_cred - int'(m_valid) + int'(noc_tx_credit);
         tick;
         if (acc_r) begin rep_tvalid = 1'b0; r_left--; end
         if (acc_q) begin req_tvalid = 1'b0; q_left--; end
      end
      idle_inputs;
   endtask

   initial begin
      test_reset;
      test_req_packet;
      test_credit_stall;
      test_starvation_order;
      test_mid_packet_hold;
      test_credit_simultaneous;
      test_random;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
